// File: rtl/weight_fetch_ctrl_pkg.sv
// weight_fetch_ctrl_pkg: shared types and constants for the weight-buffer fetch path
package weight_fetch_ctrl_pkg;
  localparam int BYTE_WIDTH = 8;
  localparam int WEIGHT_ADDRESS_WIDTH = 15;
  localparam int WEIGHT_READ_LATENCY = 3;
  typedef logic [BYTE_WIDTH-1:0] BYTE_TYPE;
  typedef logic [WEIGHT_ADDRESS_WIDTH-1:0] weight_address_type;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/weight_fetch_fifo.sv
// weight_fetch_fifo: first-word-fall-through FIFO of {last, row}
module weight_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 113
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic empty,
  output logic full
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= do_push ? (wr_ptr == PW'(DEPTH-1) ? '0 : wr_ptr + 1'b1) : wr_ptr;
      rd_ptr <= do_pop ? (rd_ptr == PW'(DEPTH-1) ? '0 : rd_ptr + 1'b1) : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: issues sequential weight-buffer reads and streams rows out under credit control
module weight_fetch_ctrl
  import weight_fetch_ctrl_pkg::*;
#(
  parameter int MATRIX_WIDTH = 14,
  parameter int TILE_WIDTH = 32768,
  parameter int READ_LATENCY = WEIGHT_READ_LATENCY,
  parameter int FIFO_DEPTH = 4,
  parameter int ROWS_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  weight_address_type cmd_addr,
  input  logic [ROWS_WIDTH-1:0] cmd_rows,
  output weight_address_type wb_address,
  output logic wb_en,
  output logic wb_write_en,
  output logic wb_enable,
  input  BYTE_TYPE [MATRIX_WIDTH-1:0] wb_read_data,
  output logic out_valid,
  input  logic out_ready,
  output BYTE_TYPE [MATRIX_WIDTH-1:0] out_data,
  output logic out_last,
  output logic busy
);
  localparam int RW = MATRIX_WIDTH * BYTE_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int IW = $clog2(READ_LATENCY+1);
  localparam int OW = 8;
  fetch_state_t state;
  weight_address_type next_addr;
  logic [ROWS_WIDTH-1:0] remaining;
  logic [READ_LATENCY-1:0] vld_sr, last_sr;
  logic [IW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [RW:0] fifo_dout;
  logic fifo_empty, fifo_full, push, pop, issue, last_issue;
  assign push = vld_sr[READ_LATENCY-1];
  assign pop = out_valid && out_ready;
  // every issued row already owns a FIFO slot, so the buffer pipeline never needs to stall
  assign issue = !rst && state == FETCH && remaining != '0 &&
                 OW'(inflight) + OW'(fifo_count) - OW'(pop) < OW'(FIFO_DEPTH);
  assign last_issue = issue && remaining == ROWS_WIDTH'(1);
  assign wb_en = issue;
  assign wb_address = next_addr;
  assign wb_write_en = 1'b0;
  assign wb_enable = !rst;
  assign cmd_ready = !rst && state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = !fifo_empty;
  assign out_last = fifo_dout[RW];
  assign out_data = fifo_dout[RW-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      next_addr <= '0;
      remaining <= '0;
      vld_sr <= '0;
      last_sr <= '0;
      inflight <= '0;
    end else begin
      vld_sr <= {vld_sr[READ_LATENCY-2:0], issue};
      last_sr <= {last_sr[READ_LATENCY-2:0], last_issue};
      inflight <= inflight + IW'(issue) - IW'(push);
      case (state)
        IDLE: if (cmd_valid) begin
          next_addr <= cmd_addr;
          remaining <= cmd_rows;
          state <= cmd_rows != '0 ? FETCH : IDLE;
        end
        FETCH: if (issue) begin
          next_addr <= next_addr == weight_address_type'(TILE_WIDTH-1) ? '0 : next_addr + 1'b1;
          remaining <= remaining - 1'b1;
          state <= last_issue ? DRAIN : FETCH;
        end
        default: state <= inflight == '0 && fifo_count == CW'(pop) ? IDLE : DRAIN;
      endcase
    end
  end
  always_ff @(posedge clk) if (!rst) assert (!(push && fifo_full && !pop));
  weight_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(RW+1)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({last_sr[READ_LATENCY-1], wb_read_data}),
    .pop(pop),
    .dout(fifo_dout),
    .count(fifo_count),
    .empty(fifo_empty),
    .full(fifo_full)
  );
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb_weight_fetch_ctrl: randomized scoreboard bench for weight_fetch_ctrl against a buffer model
`timescale 1ns/1ps
module tb_weight_fetch_ctrl;
  import weight_fetch_ctrl_pkg::*;
  localparam int MW = 14;
  localparam int TW = 32768;
  localparam int DEPTH = 4;
  localparam int RW = MW * 8;
  logic clk = 0, rst = 1, cmd_valid = 0, out_ready = 1;
  weight_address_type cmd_addr, wb_address;
  logic [15:0] cmd_rows;
  logic wb_en, wb_write_en, wb_enable, cmd_ready, out_valid, out_last, busy;
  logic [RW-1:0] p0, p1, rd, out_data;
  logic rnd_mode = 0, hold_low = 0;
  int checks = 0, fails = 0, outstanding = 0;
  logic held = 0;
  logic [RW+1:0] held_v;
  logic [RW:0] exp_rows[$];
  weight_address_type exp_addr[$];

  always #5 clk = ~clk;

  weight_fetch_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rows(cmd_rows), .wb_address(wb_address),
    .wb_en(wb_en), .wb_write_en(wb_write_en), .wb_enable(wb_enable),
    .wb_read_data(rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  function automatic logic [RW-1:0] ram_row(input int a);
    logic [RW-1:0] r;
    for (int i = 0; i < MW; i++)
      r[i*8 +: 8] = a == 0 ? (i == 0 ? 8'h80 : 8'h00) : a == 1 ? 8'h00 : 8'((a * 37 + i * 11 + (a >> 5)) ^ 'h5a);
    return r;
  endfunction

  // weight buffer: data valid three cycles after wb_en is sampled, junk otherwise
  always @(posedge clk) begin
    p0 <= wb_en ? ram_row(int'(wb_address)) : RW'({$urandom, $urandom, $urandom, $urandom});
    p1 <= p0;
    rd <= p1;
  end

  always @(posedge clk) begin
    #1;
    out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : !hold_low;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic pop;
    pop = out_valid && out_ready;
    if (rst) begin
      exp_rows.delete();
      exp_addr.delete();
      outstanding = 0;
      held = 0;
    end else begin
      if (held) chk("hold_stable", {out_valid, out_last, out_data}, held_v);
      if (wb_en) begin
        chk("credit_limit", 128'(outstanding + 1 - int'(pop) <= DEPTH), 1);
        if (exp_addr.size() == 0) chk("spurious_wb_en", 1, 0);
        else chk("wb_address", wb_address, exp_addr.pop_front());
      end
      if (pop) begin
        if (exp_rows.size() == 0) chk("spurious_row", 1, 0);
        else chk("row", {out_last, out_data}, exp_rows.pop_front());
      end
      outstanding += int'(wb_en) - int'(pop);
      held = out_valid && !out_ready;
      held_v = {1'b1, out_last, out_data};
    end
  end

  task automatic send_cmd(input int a, input int r);
    int n = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1;
    cmd_addr = weight_address_type'(a);
    cmd_rows = 16'(r);
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1);
    for (int i = 0; i < r; i++) begin
      exp_addr.push_back(weight_address_type'((a + i) % TW));
      exp_rows.push_back({i == r - 1, ram_row((a + i) % TW)});
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || out_valid || exp_rows.size() != 0) && n < 2000);
    chk("drain_timeout", n < 2000, 1);
    @(negedge clk);
    chk("cmd_ready_after_done", {cmd_ready, busy}, 2'b10);
  endtask

  task automatic wait_en(output int ok);
    int n = 0;
    @(negedge clk);
    while (!wb_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = int'(wb_en);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok, k, n;
    cmd_addr = '0;
    cmd_rows = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wb_enable", wb_enable, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_state", {cmd_ready, wb_en, wb_address, wb_enable, wb_write_en, out_valid, out_last, busy},
        {1'b1, 1'b0, 15'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_out_data", out_data, 0);

    send_cmd(0, 2);
    wait_en(ok);
    chk("first_wb_en_seen", ok, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    chk("first_row_latency", k, 4);
    wait_done();

    send_cmd(100, 16);
    fork
      begin
        int m = 0;
        wait_en(ok);
        while (wb_en && m < 40) begin
          m++;
          @(negedge clk);
        end
        chk("stream_issue_run", m, 16);
      end
      begin
        int m = 0, w = 0;
        @(negedge clk);
        while (!out_valid && w < 40) begin
          @(negedge clk);
          w++;
        end
        while (out_valid && out_ready && m < 40) begin
          m++;
          @(negedge clk);
        end
        chk("stream_row_run", m, 16);
      end
    join
    wait_done();

    send_cmd(200, 10);
    repeat (4) @(negedge clk);
    hold_low = 1;
    repeat (8) @(negedge clk);
    hold_low = 0;
    wait_done();

    send_cmd(TW - 2, 4);
    wait_done();
    send_cmd(7, 0);
    repeat (6) begin
      @(negedge clk);
      chk("zero_len_idle", {cmd_ready, wb_en, out_valid, busy}, 4'b1000);
    end

    send_cmd(300, 8);
    n = 0;
    k = 0;
    while (n < 3 && k < 50) begin
      @(negedge clk);
      n += int'(wb_en);
      k++;
    end
    chk("mid_fetch_issues", n, 3);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_reset_out_valid", {out_valid, busy}, 2'b00);
    repeat (10) @(negedge clk);
    send_cmd(5, 1);
    wait_done();

    @(negedge clk);
    rnd_mode = 1;
    for (int t = 0; t < 10; t++)
      send_cmd($urandom_range(0, 1) != 0 ? TW - 1 - int'($urandom_range(0, 5)) : int'($urandom_range(0, TW - 1)),
               int'($urandom_range(0, 12)));
    wait_done();
    rnd_mode = 0;

    chk("queues_empty", exp_rows.size() + exp_addr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
